// File: rtl/stopwatch_bcd.sv
// HH:MM:SS.CC stopwatch with lap freeze, driving eight BCD digits for seven-segment decoders.
// All outputs are registered from next-state values so the display tracks the count on the same edge.
module stopwatch_bcd #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        lap_reset,
  output logic [31:0] numbers,
  output logic        running,
  output logic        lap_active
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [31:0]   count, count_nxt;
  logic [31:0]   lap_count, lap_nxt;
  logic          counting;
  logic          tick;

  // Digits 3 and 5 are the tens of seconds and minutes; everything else rolls at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return ((idx == 3) || (idx == 5)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign counting = (state == S_RUN) || (state == S_LAP);
  assign tick     = counting && (presc == PRESC_MAX);

  // start_stop wins over lap_reset whenever both arrive together.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_stop) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start_stop)     state_nxt = S_PAUSE;
        else if (lap_reset) state_nxt = S_LAP;
      end
      S_LAP: begin
        if (start_stop)     state_nxt = S_PAUSE;
        else if (lap_reset) state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (start_stop)     state_nxt = S_RUN;
        else if (lap_reset) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counting follows the current state, so a tick on the pausing edge still lands.
  always_comb begin
    presc_nxt = presc;
    count_nxt = count;
    lap_nxt   = lap_count;
    if ((state == S_IDLE) || (state_nxt == S_IDLE)) begin
      presc_nxt = '0;
      count_nxt = '0;
    end else if (counting) begin
      if (tick) begin
        presc_nxt = '0;
        count_nxt = bcd_inc(count);
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
    if ((state == S_RUN) && (state_nxt == S_LAP)) lap_nxt = count;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      presc      <= '0;
      count      <= '0;
      lap_count  <= '0;
      numbers    <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      count      <= count_nxt;
      lap_count  <= lap_nxt;
      numbers    <= (state_nxt == S_LAP) ? lap_nxt : count_nxt;
      running    <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      lap_active <= (state_nxt == S_LAP);
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd at CLK_HZ=100, TICK_HZ=10 (one count step every 10 clocks).
module tb_stopwatch_bcd;

  logic        clk;
  logic        rst_n;
  logic        start_stop;
  logic        lap_reset;
  logic [31:0] numbers;
  logic        running;
  logic        lap_active;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd #(.CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .numbers    (numbers),
    .running    (running),
    .lap_active (lap_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap_reset = 1'b1;
    step(1);
    lap_reset = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] num, input logic run, input logic lap);
    check({tag, "_numbers"}, numbers, num);
    check({tag, "_running"}, 32'(running), 32'(run));
    check({tag, "_lap_active"}, 32'(lap_active), 32'(lap));
  endtask

  initial begin
    rst_n      = 1'b0;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    step(3);
    check_outs("reset_hold", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(2);
    check_outs("idle", 32'h0, 1'b0, 1'b0);

    // lap_reset in IDLE does nothing
    pulse_lap();
    step(5);
    check_outs("idle_lap_ignored", 32'h0, 1'b0, 1'b0);

    // 100 clocks of RUN -> 0.10 s
    pulse_start();
    check_outs("run_start", 32'h0, 1'b1, 1'b0);
    step(99);
    check("run_99cyc", numbers, 32'h00000009);
    step(1);
    check_outs("run_100cyc", 32'h00000010, 1'b1, 1'b0);

    // continue to 5999 ticks total, then carry into minutes
    step(59890);
    check("preload_5999", numbers, 32'h00005999);
    step(9);
    check("before_minute", numbers, 32'h00005999);
    step(1);
    check("minute_carry", numbers, 32'h00010000);

    // full-scale wrap: pause, load 99:59:59.99, resume (prescaler held at 1)
    do_reset();
    check_outs("reset2", 32'h0, 1'b0, 1'b0);
    pulse_start();
    pulse_start();
    check_outs("paused_early", 32'h0, 1'b0, 1'b0);
    force dut.count = 32'h99595999;
    step(1);
    release dut.count;
    check("wrap_loaded", numbers, 32'h99595999);
    pulse_start();
    step(8);
    check("wrap_before", numbers, 32'h99595999);
    step(1);
    check_outs("wrap_after", 32'h0, 1'b1, 1'b0);
    step(10);
    check("wrap_next", numbers, 32'h00000001);

    // lap freeze at 0.05 while live count keeps going
    do_reset();
    pulse_start();
    step(50);
    check("lap_pre", numbers, 32'h00000005);
    pulse_lap();
    check_outs("lap_enter", 32'h00000005, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("lap_frozen", numbers, 32'h00000005);
    end
    pulse_lap();
    check_outs("lap_exit", 32'h00000010, 1'b1, 1'b0);

    // pause with prescaler at 4, resume, next tick 5 clocks later
    do_reset();
    pulse_start();
    step(4);
    pulse_start();
    check_outs("pause_p4", 32'h0, 1'b0, 1'b0);
    step(30);
    check_outs("pause_hold", 32'h0, 1'b0, 1'b0);
    pulse_start();
    check("resume_running", 32'(running), 32'd1);
    step(4);
    check("resume_4cyc", numbers, 32'h0);
    step(1);
    check("resume_5cyc", numbers, 32'h00000001);
    pulse_start();
    check_outs("pause_again", 32'h00000001, 1'b0, 1'b0);
    pulse_lap();
    check_outs("pause_to_idle", 32'h0, 1'b0, 1'b0);
    step(3);
    check_outs("idle_stays", 32'h0, 1'b0, 1'b0);
    pulse_start();
    step(9);
    check("idle_restart_9", numbers, 32'h0);
    step(1);
    check("idle_restart_10", numbers, 32'h00000001);

    // simultaneous pulses in RUN, then reset in the middle of LAP
    do_reset();
    pulse_start();
    step(30);
    pulse_lap();
    check_outs("lap3", 32'h00000003, 1'b1, 1'b1);
    pulse_lap();
    check_outs("back_run", 32'h00000003, 1'b1, 1'b0);
    step(20);
    check("run_at5", numbers, 32'h00000005);
    start_stop = 1'b1;
    lap_reset  = 1'b1;
    step(1);
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    check_outs("both_pause", 32'h00000005, 1'b0, 1'b0);
    check("lap_reg_kept", dut.lap_count, 32'h00000003);
    pulse_start();
    pulse_lap();
    check_outs("lap5", 32'h00000005, 1'b1, 1'b1);
    rst_n      = 1'b0;
    start_stop = 1'b1;
    step(1);
    check_outs("reset_mid_lap", 32'h0, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);
    start_stop = 1'b0;
    check_outs("start_after_reset", 32'h0, 1'b1, 1'b0);
    step(10);
    check("count_after_reset", numbers, 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count rate in Hz (one tick = 1/100 s); DIV = CLK_HZ/TICK_HZ, which SHALL be an integer of at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start_stop  input  1  one-cycle pulse, already synchronized (button-synchronizer output).
REQ-006 SHALL have port lap_reset  input  1  one-cycle pulse, already synchronized.
REQ-007 SHALL have port numbers  output  32  eight BCD digits for the seven-segment decoders; digit i in bits [4i+3:4i]; digit0 = centisecond units, digit7 = hour tens (format HH MM SS CC).
REQ-008 SHALL have port running  output  1  high in RUN and LAP.
REQ-009 SHALL have port lap_active  output  1  high in LAP only.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, PAUSE and LAP.
REQ-011 SHALL hold a registered live count of eight BCD digits: CC 00-99, SS 00-59, MM 00-59, HH 00-99.
REQ-012 SHALL hold a registered prescaler that counts 0..DIV-1 while in RUN or LAP; tick = (prescaler == DIV-1) in RUN/LAP; on tick the prescaler returns to 0.
REQ-013 SHALL increment the live count by 1 on the same clock edge as a tick, with BCD carry CC→SS→MM→HH; every digit stays 0-9 at all times.
REQ-014 SHALL wrap 99:59:59.99 to 00:00:00.00 on a tick, with no flag.
REQ-015 SHALL hold the prescaler and live count unchanged in PAUSE.
REQ-016 SHALL force the prescaler and live count to zero in IDLE.
REQ-017 FSM transitions SHALL be:
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - RUN + lap_reset → LAP; the lap register captures the live count value present before that edge.
  - LAP + lap_reset → RUN, and the display returns to the live count.
  - LAP + start_stop → PAUSE, and the display shows the live count.
  - PAUSE + start_stop → RUN; the prescaler resumes from its held value.
  - PAUSE + lap_reset → IDLE; the count clears on the entry edge.
  - IDLE + lap_reset: ignored.
REQ-018 SHALL give start_stop priority when start_stop and lap_reset are both high in the same cycle, and lap_reset SHALL be ignored in that cycle.
REQ-019 SHALL still increment the live count if a tick coincides with RUN→PAUSE or LAP→PAUSE; the pause takes effect from the next cycle.
REQ-020 SHALL drive numbers = lap register in LAP and = live count in all other states.
REQ-021 SHALL use only registers for numbers: no combinational path from start_stop or lap_reset to numbers, running or lap_active; numbers reflects a count change in the same cycle the count register updates.
REQ-022 SHALL continue counting the live value while in LAP; ticks and wrap behave as in RUN.

Reset
REQ-023 SHALL take rst_n low at a clock edge to: state IDLE, prescaler 0, live count 0, lap register 0.
REQ-024 SHALL show the following outputs during and after reset: numbers = 32'h00000000, running = 0, lap_active = 0.
REQ-025 SHALL override all inputs with reset in any state, including mid-tick and mid-LAP; input pulses during reset are lost.
REQ-026 SHALL, on the first edge after rst_n returns high, respond normally to a start_stop pulse present in that cycle.

Verification (bench parameters CLK_HZ=100, TICK_HZ=10, so DIV=10)
REQ-027 SHALL cover: reset, then start_stop pulse, then 100 cycles → numbers = 32'h00000010, running = 1.
REQ-028 SHALL cover: preload via 5999 ticks to 00:00:59.99, then one more tick → numbers = 32'h00010000 (00:01:00.00).
REQ-029 SHALL cover: count 99:59:59.99 plus one tick → numbers = 0, state still RUN.
REQ-030 SHALL cover: RUN at 00:00:00.05 → lap_reset → numbers frozen at 32'h00000005 for 50 cycles, lap_active = 1; second lap_reset → numbers = 32'h00000010.
REQ-031 SHALL cover: RUN, start_stop on prescaler = 4; PAUSE 30 cycles; start_stop → the next tick arrives exactly 5 cycles after resume; then start_stop, lap_reset → numbers = 0, state IDLE.
REQ-032 SHALL cover: start_stop and lap_reset high together in RUN → state PAUSE, lap register unchanged; rst_n low mid-LAP → all outputs zero on the next edge.
